// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
package mac_dot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int DEFAULT_MAC_LATENCY = 9;

endpackage

// File: rtl/mac_dot_sequencer_issue_pipe.sv
// One-cycle alignment stage between the operand RAM read strobe and the MAC input beat.
module mac_dot_sequencer_issue_pipe (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        first_issue,
    input  logic [31:0] rd_data_a,
    input  logic [31:0] rd_data_b,
    output logic        mac_ivalid,
    output logic        mac_control,
    output logic [31:0] mac_datainA,
    output logic [31:0] mac_datainB
);

    logic ivalid_reg;
    logic control_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            ivalid_reg  <= 1'b0;
            control_reg <= 1'b0;
        end else begin
            ivalid_reg  <= rd_en;
            control_reg <= rd_en & first_issue;
        end
    end

    // RAM output register already provides the one-cycle alignment for the data.
    assign mac_ivalid  = ivalid_reg;
    assign mac_control = control_reg;
    assign mac_datainA = rd_data_a;
    assign mac_datainB = rd_data_b;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeder for the streaming FP32 MAC: reads operand pairs, tags vector start, captures the final sum.
// Build option: define MAC_WATCHDOG_EN to abort a stalled DRAIN with error=1 and a qNaN result.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 11,
    parameter int MAC_LATENCY = DEFAULT_MAC_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic              mac_ivalid,
    output logic              mac_control,
    output logic [31:0]       mac_datainA,
    output logic [31:0]       mac_datainB,
    input  logic              mac_oready,
    input  logic              mac_ovalid,
    input  logic [31:0]       mac_dataout
);

    if (MAC_LATENCY < 1) begin : g_latency_check
        $error("MAC_LATENCY must be positive");
    end

    seq_state_t        state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  issue_cnt_reg;
    logic [LEN_W-1:0]  ret_cnt_reg;
    logic [31:0]       result_reg;
    logic              in_run;
    logic              last_issue;
    logic              last_return;

    assign in_run      = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign last_issue  = (issue_cnt_reg == len_reg - LEN_W'(1));
    assign last_return = in_run && mac_ovalid && (ret_cnt_reg + LEN_W'(1) == len_reg);

`ifdef MAC_WATCHDOG_EN
    localparam int WD_LIMIT = 4 * MAC_LATENCY;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            error_reg;
    logic            wd_trip;

    // Trips on the cycle the silent-beat count would reach the limit.
    assign wd_trip = (state_reg == ST_DRAIN) && !mac_ovalid &&
                     (wd_cnt_reg == WD_W'(WD_LIMIT - 1));
    assign error   = error_reg;
`else
    assign error   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            result_reg    <= FP_ZERO;
`ifdef MAC_WATCHDOG_EN
            wd_cnt_reg    <= '0;
            error_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        base_reg      <= base_addr;
                        len_reg       <= vec_len;
                        issue_cnt_reg <= '0;
                        ret_cnt_reg   <= '0;
                        result_reg    <= FP_ZERO;
`ifdef MAC_WATCHDOG_EN
                        error_reg     <= 1'b0;
`endif
                        state_reg     <= (vec_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mac_oready) begin
                        issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
                        if (last_issue) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: ;
            endcase

            if (in_run && mac_ovalid) begin
                ret_cnt_reg <= ret_cnt_reg + LEN_W'(1);
            end
            if (last_return) begin
                result_reg <= mac_dataout;
                state_reg  <= ST_DONE;
            end

`ifdef MAC_WATCHDOG_EN
            if (state_reg == ST_DRAIN && !mac_ovalid) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end else begin
                wd_cnt_reg <= '0;
            end
            if (wd_trip) begin
                error_reg  <= 1'b1;
                result_reg <= FP_QNAN;
                state_reg  <= ST_DONE;
            end
`endif
        end
    end

    // Read strobe follows mac_oready in the same cycle so a stalled MAC never loses an issue slot.
    assign rd_en   = (state_reg == ST_FETCH) && mac_oready;
    assign rd_addr = base_reg + issue_cnt_reg[ADDR_W-1:0];
    assign busy    = in_run;
    assign done    = (state_reg == ST_DONE);
    assign result  = result_reg;

    mac_dot_sequencer_issue_pipe u_issue_pipe (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .first_issue (issue_cnt_reg == '0),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .mac_ivalid  (mac_ivalid),
        .mac_control (mac_control),
        .mac_datainA (mac_datainA),
        .mac_datainB (mac_datainB)
    );

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a registered-read operand RAM and a latency-9 FP32 MAC model.
module tb_mac_dot_sequencer;

    localparam int ADDR_W  = 10;
    localparam int LEN_W   = 11;
    localparam int MAC_LAT = 9;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  vec_len = '0;
    logic              busy, done, error, rd_en;
    logic [31:0]       result;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data_a = '0;
    logic [31:0]       rd_data_b = '0;
    logic              mac_ivalid, mac_control, mac_ovalid;
    logic              mac_oready = 1'b1;
    logic              mac_drop = 1'b0;
    logic [31:0]       mac_datainA, mac_datainB, mac_dataout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    int last_ivalid_cyc = 0;
    int ctrl_orphan = 0;
    bit busy_seen = 0;

    logic [31:0]       mem_a [1024];
    logic [31:0]       mem_b [1024];
    logic              pipe_v [MAC_LAT];
    logic [31:0]       pipe_d [MAC_LAT];
    real               acc = 0.0;

    logic [ADDR_W-1:0] exp_addr_q[$], obs_addr_q[$];
    logic [31:0]       exp_res_q[$], obs_res_q[$];
    int                exp_done_q[$], obs_done_q[$];
    logic              obs_err_q[$], obs_ctrl_q[$];

    mac_dot_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .vec_len(vec_len),
        .busy(busy), .done(done), .result(result), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mac_ivalid(mac_ivalid), .mac_control(mac_control),
        .mac_datainA(mac_datainA), .mac_datainB(mac_datainB),
        .mac_oready(mac_oready), .mac_ovalid(mac_ovalid), .mac_dataout(mac_dataout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // FP32 <-> real via the FP64 layout; exact for the normal values used here.
    function automatic real f32_to_real(input logic [31:0] f);
        if (f[30:0] == '0) return 0.0;
        return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    always @(posedge clock) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    always @(posedge clock) begin
        if (mac_ivalid) begin
            real p;
            p = f32_to_real(mac_datainA) * f32_to_real(mac_datainB);
            acc = mac_control ? p : acc + p;
        end
        pipe_v[0] <= mac_ivalid & !mac_drop;
        pipe_d[0] <= real_to_f32(acc);
        for (int i = 1; i < MAC_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mac_ovalid = pipe_v[MAC_LAT-1];
    assign mac_dataout = pipe_d[MAC_LAT-1];

    always @(negedge clock) begin
        if (rd_en === 1'b1) obs_addr_q.push_back(rd_addr);
        if (mac_ivalid === 1'b1) begin
            obs_ctrl_q.push_back(mac_control);
            last_ivalid_cyc = cyc;
        end
        if (mac_control === 1'b1 && mac_ivalid !== 1'b1) ctrl_orphan++;
        if (busy === 1'b1) busy_seen = 1;
        if (done === 1'b1) begin
            obs_res_q.push_back(result);
            obs_err_q.push_back(error);
            obs_done_q.push_back(cyc);
        end
    end

    task automatic clear_obs;
        exp_addr_q.delete(); obs_addr_q.delete();
        exp_res_q.delete();  obs_res_q.delete();
        exp_done_q.delete(); obs_done_q.delete();
        obs_err_q.delete();  obs_ctrl_q.delete();
        busy_seen = 0;
    endtask

    task automatic push_addrs(input logic [ADDR_W-1:0] b, input int n);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(b + ADDR_W'(i));
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        @(posedge clock); #1;
        start = 1'b1; base_addr = b; vec_len = n; t0 = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && obs_res_q.size() == 0; k++) @(negedge clock);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({busy, done, error, rd_en, mac_ivalid, mac_control} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, done, error, rd_en, mac_ivalid, mac_control});
        end
        vectors++;
        if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 00000000", result); end
        vectors++;
        if (rd_addr !== '0) begin miscompares++; $display("FAIL reset_rd_addr: got %h want 000", rd_addr); end
        @(posedge clock); #1;
        reset = 1'b0;
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_basic;
        logic [31:0] a_vals [4];
        logic [31:0] got_r;
        logic [ADDR_W-1:0] got_a, exp_a;
        int ones;
        a_vals = '{F1, F2, F3, F4};
        for (int i = 0; i < 4; i++) begin mem_a[16+i] = a_vals[i]; mem_b[16+i] = F1; end
        clear_obs();
        exp_res_q.push_back(32'h4120_0000); exp_done_q.push_back(15); push_addrs(10'h010, 4);
        do_start(10'h010, 11'd4);
        wait_done(60);
        vectors++;
        if (obs_done_q.size() != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", obs_done_q.size()); end
        else begin
            got_r = obs_res_q.pop_front();
            vectors++;
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL basic_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_done_q[0] - t0 != exp_done_q[0]) begin miscompares++; $display("FAIL basic_done_cycle: got %0d want %0d", obs_done_q[0] - t0, exp_done_q[0]); end
            vectors++;
            if (obs_err_q[0] !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b want 0", obs_err_q[0]); end
        end
        while (exp_addr_q.size() != 0) begin
            exp_a = exp_addr_q.pop_front();
            got_a = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
            vectors++;
            if (got_a !== exp_a) begin miscompares++; $display("FAIL basic_rd_addr: got %h want %h", got_a, exp_a); end
        end
        ones = 0;
        foreach (obs_ctrl_q[i]) if (obs_ctrl_q[i] === 1'b1) ones++;
        vectors++;
        if (obs_ctrl_q.size() != 4 || obs_ctrl_q[0] !== 1'b1 || ones != 1 || ctrl_orphan != 0) begin
            miscompares++;
            $display("FAIL basic_control: beats %0d first %b ones %0d orphan %0d want 4/1/1/0", obs_ctrl_q.size(), obs_ctrl_q[0], ones, ctrl_orphan);
        end
        vectors++;
        if (!busy_seen) begin miscompares++; $display("FAIL basic_busy: got 0 want 1 during run"); end
        $display("basic: len 4 result %h", result);
    endtask

    task automatic test_single;
        logic [31:0] got_r;
        mem_a[32] = F2; mem_b[32] = F3;
        clear_obs();
        exp_res_q.push_back(32'h40C0_0000); exp_done_q.push_back(12);
        do_start(10'h020, 11'd1);
        wait_done(40);
        vectors++;
        if (obs_res_q.size() == 0) begin miscompares++; $display("FAIL single_done: got none want 1"); end
        else begin
            got_r = obs_res_q.pop_front();
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL single_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_done_q[0] - t0 != exp_done_q[0]) begin miscompares++; $display("FAIL single_done_cycle: got %0d want %0d", obs_done_q[0] - t0, exp_done_q[0]); end
        end
        vectors++;
        if (obs_ctrl_q.size() != 1 || obs_ctrl_q[0] !== 1'b1 || ctrl_orphan != 0) begin
            miscompares++;
            $display("FAIL single_control: beats %0d orphan %0d want 1 beat with control", obs_ctrl_q.size(), ctrl_orphan);
        end
        $display("single: len 1 result %h", result);
    endtask

    task automatic test_zero_len;
        logic [31:0] got_r;
        clear_obs();
        exp_res_q.push_back(32'h0); exp_done_q.push_back(1);
        do_start(10'h000, 11'd0);
        wait_done(10);
        vectors++;
        if (obs_res_q.size() == 0) begin miscompares++; $display("FAIL zero_done: got none want 1"); end
        else begin
            got_r = obs_res_q.pop_front();
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL zero_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_done_q[0] - t0 != exp_done_q[0]) begin miscompares++; $display("FAIL zero_done_cycle: got %0d want %0d", obs_done_q[0] - t0, exp_done_q[0]); end
        end
        vectors++;
        if (obs_addr_q.size() != 0 || busy_seen) begin
            miscompares++;
            $display("FAIL zero_activity: reads %0d busy %b want 0/0", obs_addr_q.size(), busy_seen);
        end
        $display("zero: len 0 result %h", result);
    endtask

    task automatic test_back_to_back;
        logic [31:0] got_r;
        logic [ADDR_W-1:0] got_a, exp_a;
        for (int i = 0; i < 8; i++) begin mem_a[256+i] = F1; mem_b[256+i] = F1; end
        clear_obs();
        exp_res_q.push_back(32'h4100_0000); exp_done_q.push_back(22); push_addrs(10'h100, 8);
        do_start(10'h100, 11'd8);
        for (int k = 1; k < 60 && obs_res_q.size() == 0; k++) begin
            mac_oready = !(k >= 3 && k <= 5);
            start = (k == 7);
            if (k == 7) begin base_addr = 10'h200; vec_len = 11'd2; end
            @(posedge clock); #1;
        end
        mac_oready = 1'b1; start = 1'b0;
        wait_done(10);
        vectors++;
        if (obs_done_q.size() != 1) begin miscompares++; $display("FAIL bp_done_count: got %0d want 1", obs_done_q.size()); end
        else begin
            got_r = obs_res_q.pop_front();
            vectors++;
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL bp_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_done_q[0] - t0 != exp_done_q[0]) begin miscompares++; $display("FAIL bp_done_cycle: got %0d want %0d", obs_done_q[0] - t0, exp_done_q[0]); end
        end
        vectors++;
        if (obs_addr_q.size() != 8) begin miscompares++; $display("FAIL bp_read_count: got %0d want 8", obs_addr_q.size()); end
        while (exp_addr_q.size() != 0) begin
            exp_a = exp_addr_q.pop_front();
            got_a = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
            vectors++;
            if (got_a !== exp_a) begin miscompares++; $display("FAIL bp_rd_addr: got %h want %h", got_a, exp_a); end
        end
        $display("backpressure: len 8 result %h", result);

        for (int i = 0; i < 4; i++) begin mem_a[(1022+i) % 1024] = F2; mem_b[(1022+i) % 1024] = F2; end
        clear_obs();
        exp_res_q.push_back(32'h4180_0000); push_addrs(10'h3FE, 4);
        do_start(10'h3FE, 11'd4);
        wait_done(60);
        vectors++;
        if (obs_res_q.size() == 0) begin miscompares++; $display("FAIL wrap_done: got none want 1"); end
        else begin
            got_r = obs_res_q.pop_front();
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL wrap_result: got %h want %h", got_r, exp_res_q[0]); end
        end
        while (exp_addr_q.size() != 0) begin
            exp_a = exp_addr_q.pop_front();
            got_a = (obs_addr_q.size() != 0) ? obs_addr_q.pop_front() : 'x;
            vectors++;
            if (got_a !== exp_a) begin miscompares++; $display("FAIL wrap_rd_addr: got %h want %h", got_a, exp_a); end
        end
        $display("wrap: base 3fe len 4 result %h", result);
    endtask

    task automatic test_reset_mid;
        logic [31:0] got_r;
        for (int i = 0; i < 16; i++) begin mem_a[64+i] = F1; mem_b[64+i] = F1; end
        mem_a[96] = F1; mem_a[97] = F1; mem_b[96] = F2; mem_b[97] = F2;
        clear_obs();
        do_start(10'h040, 11'd16);
        repeat (19) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({busy, done, rd_en, mac_ivalid} !== 4'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b want 0000", {busy, done, rd_en, mac_ivalid});
        end
        busy_seen = 0;
        repeat (15) @(negedge clock);
        vectors++;
        if (obs_res_q.size() != 0 || busy_seen) begin
            miscompares++;
            $display("FAIL midreset_stale: done %0d busy %b want 0/0", obs_res_q.size(), busy_seen);
        end
        clear_obs();
        exp_res_q.push_back(32'h4080_0000); exp_done_q.push_back(13);
        do_start(10'h060, 11'd2);
        wait_done(40);
        vectors++;
        if (obs_res_q.size() == 0) begin miscompares++; $display("FAIL postreset_done: got none want 1"); end
        else begin
            got_r = obs_res_q.pop_front();
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL postreset_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_done_q[0] - t0 != exp_done_q[0]) begin miscompares++; $display("FAIL postreset_done_cycle: got %0d want %0d", obs_done_q[0] - t0, exp_done_q[0]); end
        end
        $display("reset_mid: follow-up len 2 result %h", result);
    endtask

`ifdef MAC_WATCHDOG_EN
    task automatic test_watchdog;
        logic [31:0] got_r;
        for (int i = 0; i < 3; i++) begin mem_a[128+i] = F1; mem_b[128+i] = F1; end
        clear_obs();
        mac_drop = 1'b1;
        exp_res_q.push_back(32'h7FC0_0000);
        do_start(10'h080, 11'd3);
        wait_done(100);
        mac_drop = 1'b0;
        vectors++;
        if (obs_res_q.size() == 0) begin miscompares++; $display("FAIL wd_done: got none want 1"); end
        else begin
            got_r = obs_res_q.pop_front();
            if (got_r !== exp_res_q[0]) begin miscompares++; $display("FAIL wd_result: got %h want %h", got_r, exp_res_q[0]); end
            vectors++;
            if (obs_err_q[0] !== 1'b1) begin miscompares++; $display("FAIL wd_error: got %b want 1", obs_err_q[0]); end
            vectors++;
            if (obs_done_q[0] - last_ivalid_cyc != 36) begin
                miscompares++;
                $display("FAIL wd_timing: got %0d want 36 cycles after last ivalid", obs_done_q[0] - last_ivalid_cyc);
            end
        end
        vectors++;
        if (error !== 1'b1) begin miscompares++; $display("FAIL wd_sticky: got %b want 1", error); end
        clear_obs();
        do_start(10'h020, 11'd1);
        wait_done(40);
        vectors++;
        if (obs_err_q.size() == 0 || obs_err_q[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_clear: error not cleared by new start");
        end
        $display("watchdog: result %h error %b", result, error);
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        for (int i = 0; i < MAC_LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
        test_reset();
        test_basic();
        test_single();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
`ifdef MAC_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
